inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 181 ++++++++++++++++++
 tb/tb_inst_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction loader: parses a length-prefixed byte stream into 16-bit words,
// writes them into instruction RAM, verifies an XOR checksum and controls the
// processor reset accordingly.
module inst_loader #(
    parameter int DATA_WIDTH     = 16,
    parameter int PC_WIDTH       = 8,
    parameter int INST_RAM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_wr_en,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [PC_WIDTH:0]     words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam logic [PC_WIDTH-1:0] ADDR_MAX = PC_WIDTH'(INST_RAM_DEPTH - 1);

    state_t                  state_q;
    logic [7:0]              len_hi_q;
    logic [15:0]             len_q;
    logic [15:0]             cnt_q;
    logic [7:0]              hi_q;
    logic [7:0]              csum_q;
    logic                    wr_en_q;
    logic [PC_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [PC_WIDTH:0]       loaded_q;
    logic                    cpu_rst_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    accept;
    logic [15:0]             len_rx;
    logic [15:0]             cnt_next;

    // Byte handshake: ready only in the states that consume stream bytes
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: rx_ready = 1'b1;
            default:                                 rx_ready = 1'b0;
        endcase
        accept   = rx_valid && rx_ready;
        len_rx   = {len_hi_q, rx_data};
        cnt_next = cnt_q + 16'd1;
    end

    // Loader FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_hi_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            loaded_q  <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            // Address advances after each write but saturates at the last
            // RAM entry so a full-depth load never wraps.
            if (wr_en_q && (addr_q != ADDR_MAX)) begin
                addr_q <= addr_q + PC_WIDTH'(1);
            end

            case (state_q)
                IDLE, DONE, ERR: begin
                    if (state_q == DONE) begin
                        cpu_rst_q <= 1'b0;
                    end
                    if (start) begin
                        state_q   <= LEN_HI;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        loaded_q  <= '0;
                        addr_q    <= '0;
                        csum_q    <= '0;
                        cnt_q     <= '0;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= rx_data;
                        state_q  <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len_q <= len_rx;
                        if ((len_rx == 16'd0) ||
                            (32'(len_rx) > 32'(INST_RAM_DEPTH))) begin
                            state_q <= ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DATA_HI;
                        end
                    end
                end

                DATA_HI: begin
                    if (accept) begin
                        hi_q    <= rx_data;
                        csum_q  <= csum_q ^ rx_data;
                        state_q <= DATA_LO;
                    end
                end

                DATA_LO: begin
                    if (accept) begin
                        csum_q   <= csum_q ^ rx_data;
                        wr_en_q  <= 1'b1;
                        wdata_q  <= DATA_WIDTH'({hi_q, rx_data});
                        loaded_q <= loaded_q + (PC_WIDTH + 1)'(1);
                        cnt_q    <= cnt_next;
                        state_q  <= (cnt_next == len_q) ? CHECK : DATA_HI;
                    end
                end

                CHECK: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_wr_en    = wr_en_q;
    assign mem_addr     = addr_q;
    assign mem_wr_data  = wdata_q;
    assign words_loaded = loaded_q;
    assign cpu_reset    = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of byte streams with expected
// outcomes, plus hand sequences for full-depth, mid-load reset and restart.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int tests = 0;
    int fails = 0;

    int          wcount;
    int          acc;
    logic [7:0]  wr_addr [0:299];
    logic [15:0] wr_data [0:299];

    typedef struct {
        int          nbytes;
        logic [79:0] bytes;     // stream, first byte in the top 8 bits
        bit          stall;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
    } vec_t;

    vec_t vecs [0:6];

    inst_loader #(
        .DATA_WIDTH     (16),
        .PC_WIDTH       (8),
        .INST_RAM_DEPTH (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture RAM writes and consumed bytes in the middle of the low phase
    always @(negedge clk) begin
        #1;
        if (mem_wr_en) begin
            if (wcount < 300) begin
                wr_addr[wcount] = mem_addr;
                wr_data[wcount] = mem_wr_data;
            end
            wcount++;
        end
        if (rx_valid && rx_ready) acc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit sent = 1'b0;
        for (int t = 0; t < 64 && !sent; t++) begin
            rx_data  = b;
            rx_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rx_valid && rx_ready) sent = 1'b1;
            @(negedge clk);
        end
        if (!sent) begin
            tests++;
            fails++;
            $display("FAIL send_byte: byte %0h not accepted, required within 64 cycles", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wcount = 0;
        acc    = 0;
        pulse_start();
        chk($sformatf("v%0d busy after start", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d cpu_reset after start", idx), 32'(cpu_reset), 32'd1);
        chk($sformatf("v%0d flags cleared", idx), {30'd0, done, error}, 32'd0);
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(v.bytes[79 - 8 * i -: 8], v.stall);
        end
        rx_valid = 1'b0;
        // first cycle in DONE/ERR
        chk($sformatf("v%0d done", idx), 32'(done), 32'(v.exp_done));
        chk($sformatf("v%0d error", idx), 32'(error), 32'(v.exp_err));
        chk($sformatf("v%0d busy end", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d cpu_reset entry", idx), 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d cpu_reset after", idx), 32'(cpu_reset), 32'(!v.exp_done));
        chk($sformatf("v%0d words_loaded", idx), 32'(words_loaded), 32'(v.exp_words));
        chk($sformatf("v%0d write count", idx), 32'(wcount), 32'(v.exp_words));
        chk($sformatf("v%0d bytes consumed", idx), 32'(acc), 32'(v.nbytes));
        if (wcount >= 1) begin
            chk($sformatf("v%0d addr0", idx), 32'(wr_addr[0]), 32'd0);
            chk($sformatf("v%0d data0", idx), 32'(wr_data[0]), 32'(v.exp_w0));
        end
        if (wcount >= 2) begin
            chk($sformatf("v%0d addr1", idx), 32'(wr_addr[1]), 32'd1);
            chk($sformatf("v%0d data1", idx), 32'(wr_data[1]), 32'(v.exp_w1));
        end
    endtask

    initial begin
        vecs[0] = '{nbytes: 7,  bytes: 80'h0002_1234_ABCD_40_000000, stall: 1'b0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 2, exp_w0: 16'h1234, exp_w1: 16'hABCD};
        vecs[1] = '{nbytes: 7,  bytes: 80'h0002_1234_ABCD_41_000000, stall: 1'b0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 2, exp_w0: 16'h1234, exp_w1: 16'hABCD};
        vecs[2] = '{nbytes: 2,  bytes: 80'h0000_0000_0000_0000_0000, stall: 1'b0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 0, exp_w0: 16'h0000, exp_w1: 16'h0000};
        vecs[3] = '{nbytes: 2,  bytes: 80'h0101_0000_0000_0000_0000, stall: 1'b0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 0, exp_w0: 16'h0000, exp_w1: 16'h0000};
        vecs[4] = '{nbytes: 7,  bytes: 80'h0002_1234_ABCD_40_000000, stall: 1'b1,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 2, exp_w0: 16'h1234, exp_w1: 16'hABCD};
        vecs[5] = '{nbytes: 5,  bytes: 80'h0001_5AA5_FF_0000000000, stall: 1'b0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 1, exp_w0: 16'h5AA5, exp_w1: 16'h0000};
        vecs[6] = '{nbytes: 5,  bytes: 80'h0001_5AA5_00_0000000000, stall: 1'b1,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 1, exp_w0: 16'h5AA5, exp_w1: 16'h0000};

        wcount   = 0;
        acc      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Values held while reset is asserted
        chk("reset rx_ready", 32'(rx_ready), 32'd0);
        chk("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wr_data", 32'(mem_wr_data), 32'd0);
        chk("reset words_loaded", 32'(words_loaded), 32'd0);
        chk("reset flags", {29'd0, busy, done, error}, 32'd0);
        chk("reset cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle rx_ready", 32'(rx_ready), 32'd0);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
            repeat (2) @(negedge clk);
        end

        // Full-depth load: word k = {k, ~k}; every word XORs to FF, so 256 words give 00
        wcount = 0;
        acc    = 0;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), 1'b0);
            send_byte(~8'(k), 1'b0);
        end
        send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("full done", 32'(done), 32'd1);
        chk("full error", 32'(error), 32'd0);
        chk("full words_loaded", 32'(words_loaded), 32'd256);
        chk("full write count", 32'(wcount), 32'd256);
        chk("full first addr", 32'(wr_addr[0]), 32'h00);
        chk("full last addr", 32'(wr_addr[255]), 32'hFF);
        chk("full last data", 32'(wr_data[255]), 32'hFF00);
        chk("full addr saturated", 32'(mem_addr), 32'hFF);
        repeat (2) @(negedge clk);

        // Reset right after the DATA_LO accept edge cancels the pending write
        wcount = 0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("midreset mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("midreset outputs", {27'd0, rx_ready, busy, done, error, cpu_reset}, 32'd1);
        chk("midreset counters", {15'd0, words_loaded, mem_addr}, 32'd0);
        chk("midreset wdata", 32'(mem_wr_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset no writes", 32'(wcount), 32'd0);
        chk("midreset idle", {29'd0, rx_ready, busy, cpu_reset}, 32'd1);
        run_vec(vecs[0], 10);
        repeat (2) @(negedge clk);

        // Restart from DONE, with a start pulse during the load that must be ignored
        chk("restart in done", 32'(done), 32'd1);
        wcount = 0;
        pulse_start();
        chk("restart done cleared", 32'(done), 32'd0);
        chk("restart cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart busy", 32'(busy), 32'd1);
        chk("restart words cleared", 32'(words_loaded), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h5A, 1'b0);
        rx_valid = 1'b0;
        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'hFF, 1'b0);
        rx_valid = 1'b0;
        chk("restart second done", 32'(done), 32'd1);
        chk("restart second error", 32'(error), 32'd0);
        @(negedge clk);
        chk("restart write count", 32'(wcount), 32'd1);
        chk("restart addr0", 32'(wr_addr[0]), 32'd0);
        chk("restart data0", 32'(wr_data[0]), 32'h5AA5);
        chk("restart words_loaded", 32'(words_loaded), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
